uart_rx_multi: RTL and testbench

Parametrised RS-232 receiver for the host serial link. It accepts configurable frame formats: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits, and 8x or 16x oversampling. A fractional baud generator drives it, and a majority-vote input filter cleans the line. It reports parity error, framing error and line break alongside the data. Idle and end-of-packet detection let burst traffic be grouped into packets for the downstream command parser.

---
 rtl/uart_rx_multi_if.sv | 26 ++
 rtl/uart_rx_multi.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_multi_if.sv
// Receive-side signal bundle for uart_rx_multi: serial line in, decoded word and status out.
// master = receiver side, slave = line driver / consumer side.
interface uart_rx_multi_if #(
  parameter int DataBits = 8
);
  logic                RxD;
  logic                RxD_data_ready;
  logic [DataBits-1:0] RxD_data;
  logic                RxD_parity_error;
  logic                RxD_framing_error;
  logic                RxD_break;
  logic                RxD_idle;
  logic                RxD_endofpacket;

  modport master (
    input  RxD,
    output RxD_data_ready, RxD_data, RxD_parity_error, RxD_framing_error,
           RxD_break, RxD_idle, RxD_endofpacket
  );

  modport slave (
    output RxD,
    input  RxD_data_ready, RxD_data, RxD_parity_error, RxD_framing_error,
           RxD_break, RxD_idle, RxD_endofpacket
  );
endinterface

// File: rtl/uart_rx_multi.sv
// Oversampling UART receiver with fractional baud tick, majority filter, break and packet-gap detection.
// state | meaning: IDLE wait start / START validate start / DATA data bits / PARITY parity bit /
//   STOP1 first stop or break / STOP2 second stop / BRKWAIT hold until line returns high
module uart_rx_multi #(
  parameter int ClkFrequency = 32000000,
  parameter int Baud         = 2000000,
  parameter int Oversample   = 16,
  parameter int AccWidth     = 16,
  parameter int DataBits     = 8,
  parameter int Parity       = 0,
  parameter int StopBits     = 1,
  parameter int GapBits      = 2
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_multi_if.master bus
);
  localparam int TW = $clog2(Oversample);
  localparam logic [63:0] INC64 =
    (((64'(Baud) * 64'(Oversample)) << AccWidth) + 64'(ClkFrequency) / 64'd2) / 64'(ClkFrequency);
  localparam logic [AccWidth:0] INC = INC64[AccWidth:0];

  if ((64'(Baud) * 64'(Oversample)) > 64'(ClkFrequency)) begin : g_rate_err
    $error("uart_rx_multi: Baud*Oversample exceeds ClkFrequency");
  end
  if ((Oversample != 8 && Oversample != 16) || DataBits < 5 || DataBits > 9 ||
      Parity > 2 || (StopBits != 1 && StopBits != 2) || GapBits < 1 || GapBits > 15) begin : g_cfg_err
    $error("uart_rx_multi: illegal frame configuration");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;

  state_t              state_q, state_d;
  logic [AccWidth:0]   acc_q, acc_d;
  logic [1:0]          sync_q, sync_d;
  logic [2:0]          win_q, win_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [3:0]          bcnt_q, bcnt_d;
  logic [DataBits-1:0] sr_q, sr_d;
  logic                par_bit_q, par_bit_d;
  logic                perr_q, perr_d;
  logic [3:0]          gap_q, gap_d;
  logic                seen_q, seen_d;
  logic                ready_q, ready_d;
  logic                brk_q, brk_d;
  logic                eop_q, eop_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                perr_out_q, perr_out_d;
  logic                ferr_q, ferr_d;

  logic tick, rx_f, mid_smp, end_smp, complete;

  assign tick    = acc_q[AccWidth];
  assign rx_f    = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
  assign mid_smp = tick && (tcnt_q == TW'(Oversample / 2 - 1));
  assign end_smp = tick && (tcnt_q == TW'(Oversample - 1));

  always_comb begin
    acc_d  = {1'b0, acc_q[AccWidth-1:0]} + INC;
    sync_d = {sync_q[0], bus.RxD};
    win_d  = tick ? {win_q[1:0], sync_q[1]} : win_q;
  end

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    sr_d       = sr_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    ready_d    = 1'b0;
    brk_d      = 1'b0;
    complete   = 1'b0;
    unique case (state_q)
      IDLE:    if (tick && !rx_f) state_d = START;
      START: begin
        if (mid_smp) begin
          state_d   = rx_f ? IDLE : DATA;
          bcnt_d    = '0;
          par_bit_d = 1'b0;
          perr_d    = 1'b0;
        end
      end
      DATA: begin
        if (end_smp) begin
          sr_d   = {rx_f, sr_q[DataBits-1:1]};
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'(DataBits - 1)) state_d = (Parity != 0) ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (end_smp) begin
          par_bit_d = rx_f;
          perr_d    = rx_f != ((Parity == 2) ? ^sr_q : ~^sr_q);
          state_d   = STOP1;
        end
      end
      STOP1: begin
        if (end_smp) begin
          // all-zero frame including the stop bit is a break, not a data word
          if (sr_q == '0 && !par_bit_q && !rx_f) begin
            brk_d   = 1'b1;
            state_d = BRKWAIT;
          end else if (StopBits == 2 && rx_f) begin
            state_d = STOP2;
          end else begin
            complete = 1'b1;
            ferr_d   = !rx_f;
            state_d  = IDLE;
          end
        end
      end
      STOP2: begin
        if (end_smp) begin
          complete = 1'b1;
          ferr_d   = !rx_f;
          state_d  = IDLE;
        end
      end
      BRKWAIT: if (tick && rx_f) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (complete) begin
      ready_d    = 1'b1;
      data_d     = sr_q;
      perr_out_d = perr_q;
    end
  end

  always_comb begin
    tcnt_d = (state_d != state_q) ? '0 : (tick ? tcnt_q + TW'(1) : tcnt_q);
    gap_d  = gap_q;
    if (state_q != IDLE) gap_d = '0;
    else if (end_smp && gap_q != 4'(GapBits)) gap_d = gap_q + 4'd1;
    eop_d  = seen_q && (gap_d == 4'(GapBits)) && (gap_q != 4'(GapBits));
    seen_d = complete || (seen_q && !eop_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sync_q     <= 2'b11;
      win_q      <= 3'b111;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      sr_q       <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      gap_q      <= '0;
      seen_q     <= 1'b0;
      ready_q    <= 1'b0;
      brk_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sync_q     <= sync_d;
      win_q      <= win_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      sr_q       <= sr_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      gap_q      <= gap_d;
      seen_q     <= seen_d;
      ready_q    <= ready_d;
      brk_q      <= brk_d;
      eop_q      <= eop_d;
      data_q     <= data_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.RxD_data_ready    = ready_q;
  assign bus.RxD_data          = data_q;
  assign bus.RxD_parity_error  = perr_out_q;
  assign bus.RxD_framing_error = ferr_q;
  assign bus.RxD_break         = brk_q;
  assign bus.RxD_idle          = (gap_q == 4'(GapBits));
  assign bus.RxD_endofpacket   = eop_q;
endmodule

// File: tb/tb_uart_rx_multi.sv
// Bench for uart_rx_multi: three receivers (8N1, 8E1, 7O2) at 2 Mbaud / 16x against a frame-level model.
module tb_uart_rx_multi;
  localparam int BIT_CLKS = 16;

  typedef struct packed {
    logic [1:0] ch;
    logic       brk;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   eop_cnt_a = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  uart_rx_multi_if #(.DataBits(8)) if_a ();
  uart_rx_multi_if #(.DataBits(8)) if_b ();
  uart_rx_multi_if #(.DataBits(7)) if_c ();

  uart_rx_multi #(.DataBits(8), .Parity(0), .StopBits(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.master));
  uart_rx_multi #(.DataBits(8), .Parity(2), .StopBits(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b.master));
  uart_rx_multi #(.DataBits(7), .Parity(1), .StopBits(2)) dut_c (.clk(clk), .reset(reset), .bus(if_c.master));

  function automatic int nb(input int ch); return (ch == 2) ? 7 : 8; endfunction
  function automatic int pm(input int ch); return (ch == 0) ? 0 : ((ch == 1) ? 2 : 1); endfunction
  function automatic int ns(input int ch); return (ch == 2) ? 2 : 1; endfunction

  function automatic ev_t mk(input int ch, input bit brk, input int data, input bit perr, input bit ferr);
    ev_t e;
    e.ch = 2'(ch); e.brk = brk; e.data = 9'(data); e.perr = perr; e.ferr = ferr;
    return e;
  endfunction

  function automatic int data_val(input int ch, input logic [8:0] d);
    return int'(d) % (1 << nb(ch));
  endfunction

  function automatic logic good_par(input int ch, input logic [8:0] d);
    int v = data_val(ch, d);
    int ones = 0;
    for (int i = 0; i < nb(ch); i++) ones += (v >> i) & 1;
    return (pm(ch) == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
  endfunction

  // Frame-level expectation: what one received frame should report.
  function automatic ev_t model(input int ch, input logic [8:0] d, input logic pb, input logic s1, input logic s2);
    int  v = data_val(ch, d);
    bit  has_par = (pm(ch) != 0);
    ev_t e = mk(ch, 1'b0, v, 1'b0, 1'b0);
    if (v == 0 && (!has_par || !pb) && !s1) return mk(ch, 1'b1, 0, 1'b0, 1'b0);
    e.perr = has_par && (pb != good_par(ch, d));
    e.ferr = !s1 || (ns(ch) == 2 && !s2);
    return e;
  endfunction

  function automatic logic [14:0] outs_a();
    return {if_a.RxD_data_ready, if_a.RxD_data, if_a.RxD_parity_error, if_a.RxD_framing_error,
            if_a.RxD_break, if_a.RxD_idle, if_a.RxD_endofpacket};
  endfunction

  always @(negedge clk) begin
    if (if_a.RxD_data_ready) obs_q.push_back(mk(0, 1'b0, int'(if_a.RxD_data), if_a.RxD_parity_error, if_a.RxD_framing_error));
    if (if_a.RxD_break)      obs_q.push_back(mk(0, 1'b1, 0, 1'b0, 1'b0));
    if (if_b.RxD_data_ready) obs_q.push_back(mk(1, 1'b0, int'(if_b.RxD_data), if_b.RxD_parity_error, if_b.RxD_framing_error));
    if (if_b.RxD_break)      obs_q.push_back(mk(1, 1'b1, 0, 1'b0, 1'b0));
    if (if_c.RxD_data_ready) obs_q.push_back(mk(2, 1'b0, int'(if_c.RxD_data), if_c.RxD_parity_error, if_c.RxD_framing_error));
    if (if_c.RxD_break)      obs_q.push_back(mk(2, 1'b1, 0, 1'b0, 1'b0));
    if (if_a.RxD_endofpacket) eop_cnt_a++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_queues(input string tag);
    ev_t o, e;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_event"}, 64'(o), 64'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic line_bit(input int ch, input logic b, input int clks);
    case (ch)
      0:       if_a.RxD = b;
      1:       if_b.RxD = b;
      default: if_c.RxD = b;
    endcase
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [8:0] d, input logic pb, input logic s1,
                            input logic s2, input int idle_bits);
    exp_q.push_back(model(ch, d, pb, s1, s2));
    line_bit(ch, 1'b0, BIT_CLKS);
    for (int i = 0; i < nb(ch); i++) line_bit(ch, d[i], BIT_CLKS);
    if (pm(ch) != 0) line_bit(ch, pb, BIT_CLKS);
    line_bit(ch, s1, BIT_CLKS);
    if (ns(ch) == 2) line_bit(ch, s2, BIT_CLKS);
    line_bit(ch, 1'b1, idle_bits * BIT_CLKS);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] d;
    logic       pb, s1, s2;
    int         n, eop0;
    if_a.RxD = 1'b1; if_b.RxD = 1'b1; if_c.RxD = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_outputs_during", 64'(outs_a()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs_after", 64'(outs_a()), 64'd0);
    line_bit(0, 1'b1, 4 * BIT_CLKS);

    send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1, 3);
    compare_queues("8n1_a5");
    chk("8n1_a5_data", 64'(if_a.RxD_data), 64'h0A5);
    chk("8n1_a5_flags", 64'({if_a.RxD_parity_error, if_a.RxD_framing_error}), 64'd0);

    send_frame(1, 9'h003, 1'b1, 1'b1, 1'b1, 3);
    compare_queues("8e1_bad_par");
    chk("8e1_bad_par_flag", 64'(if_b.RxD_parity_error), 64'd1);
    chk("8e1_bad_par_data", 64'(if_b.RxD_data), 64'h003);
    send_frame(1, 9'h003, 1'b0, 1'b1, 1'b1, 3);
    compare_queues("8e1_good_par");
    chk("8e1_good_par_flag", 64'(if_b.RxD_parity_error), 64'd0);

    send_frame(2, 9'h041, 1'b1, 1'b1, 1'b0, 3);
    compare_queues("7o2_stop2_low");
    chk("7o2_data", 64'(if_c.RxD_data), 64'h041);
    chk("7o2_ferr", 64'(if_c.RxD_framing_error), 64'd1);

    exp_q.push_back(mk(0, 1'b1, 0, 1'b0, 1'b0));
    line_bit(0, 1'b0, 12 * BIT_CLKS);
    line_bit(0, 1'b1, 3 * BIT_CLKS);
    compare_queues("break");
    chk("break_data_held", 64'(if_a.RxD_data), 64'h0A5);
    send_frame(0, 9'h055, 1'b0, 1'b1, 1'b1, 4);
    compare_queues("after_break");
    chk("after_break_data", 64'(if_a.RxD_data), 64'h055);

    line_bit(0, 1'b0, BIT_CLKS / 4);
    line_bit(0, 1'b1, 4 * BIT_CLKS);
    compare_queues("glitch");
    chk("glitch_idle_again", 64'(if_a.RxD_idle), 64'd1);

    eop0 = eop_cnt_a;
    send_frame(0, 9'h001, 1'b0, 1'b1, 1'b1, 0);
    send_frame(0, 9'h002, 1'b0, 1'b1, 1'b1, 0);
    send_frame(0, 9'h003, 1'b0, 1'b1, 1'b1, 0);
    n = 0;
    while (!if_a.RxD_idle && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("burst_idle_window", 64'(n >= BIT_CLKS && n <= 3 * BIT_CLKS), 64'd1);
    chk("burst_eop_with_idle", 64'(if_a.RxD_endofpacket), 64'd1);
    line_bit(0, 1'b1, 3 * BIT_CLKS);
    chk("burst_eop_once", 64'(eop_cnt_a - eop0), 64'd1);
    compare_queues("burst");

    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 8; k++) begin
        d  = 9'($urandom);
        pb = good_par(ch, d) ^ ($urandom_range(0, 3) == 0);
        s1 = ($urandom_range(0, 7) != 0);
        s2 = s1 ? ($urandom_range(0, 5) != 0) : 1'b1;
        send_frame(ch, d, pb, s1, s2,
                   (!s1 || !s2) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2)));
      end
    end
    line_bit(0, 1'b1, 3 * BIT_CLKS);
    compare_queues("random");

    eop0 = eop_cnt_a;
    line_bit(0, 1'b0, BIT_CLKS);
    line_bit(0, 1'b1, BIT_CLKS);
    line_bit(0, 1'b0, BIT_CLKS / 2);
    reset = 1'b1;
    if_a.RxD = 1'b1;
    @(negedge clk);
    chk("midreset_outputs_a", 64'(outs_a()), 64'd0);
    chk("midreset_data_c", 64'(if_c.RxD_data), 64'd0);
    reset = 1'b0;
    line_bit(0, 1'b1, 4 * BIT_CLKS);
    compare_queues("midreset");
    chk("midreset_idle_back", 64'(if_a.RxD_idle), 64'd1);
    chk("midreset_no_eop", 64'(eop_cnt_a - eop0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
